// File: rtl/dmem_pkg.sv
// Shared types and constants for the MEM-stage data-memory controller.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } dmem_state_e;

  localparam logic [31:0] DMEM_ERR_DATA = 32'hDEAD_BEEF;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } dmem_req_t;

  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Valid/ready data-bus bundle between the MEM-stage controller (master) and memory (slave).
interface dmem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic [31:0] resp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/dmem_timeout.sv
// Response watchdog: cleared on entry to WAIT, counts WAIT cycles, flags the last permitted one.
module dmem_timeout #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // r_cnt counts completed WAIT cycles, so LIMIT-1 marks the LIMIT-th one
  assign expired = en && (r_cnt == W'(LIMIT - 1));

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage data-memory access controller; stalls the pipeline around one bus access.
// Optional response watchdog and bus_err_MEM output enabled by DMEM_TIMEOUT_EN.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read_MEM,
  input  logic        mem_write_MEM,
  input  logic [31:0] addr_MEM,
  input  logic [31:0] wdata_MEM,
  input  logic [3:0]  be_MEM,
  output logic        mem_stall_MEM,
  output logic [31:0] rdata_MEM,
`ifdef DMEM_TIMEOUT_EN
  output logic        bus_err_MEM,
`endif
  dmem_ctrl_if.master bus
);

  dmem_state_e r_state;
  dmem_req_t   r_req;
  logic        r_req_valid;
  logic [31:0] r_rdata;
  logic        w_op;
  logic        w_stall;

  assign w_op = mem_read_MEM | mem_write_MEM;

`ifdef DMEM_TIMEOUT_EN
  logic r_bus_err;
  logic w_expired;

  dmem_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     ((r_state == REQ) && bus.req_ready),
    .en      (r_state == WAIT),
    .expired (w_expired)
  );

  assign bus_err_MEM = r_bus_err;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_req       <= '0;
      r_req_valid <= 1'b0;
      r_rdata     <= '0;
`ifdef DMEM_TIMEOUT_EN
      r_bus_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_op) begin
            r_req <= '{we:    mem_write_MEM,
                       addr:  word_addr(addr_MEM),
                       wdata: wdata_MEM,
                       be:    be_MEM};
            r_req_valid <= 1'b1;
            r_state     <= REQ;
          end
        end
        REQ: begin
          if (bus.req_ready) begin
            r_req_valid <= 1'b0;
            r_state     <= WAIT;
          end
        end
        WAIT: begin
          // a response on the watchdog's last cycle still completes normally
          if (bus.resp_valid) begin
            if (!r_req.we) begin
              r_rdata <= bus.resp_rdata;
            end
            r_state <= DONE;
          end
`ifdef DMEM_TIMEOUT_EN
          else if (w_expired) begin
            r_rdata   <= DMEM_ERR_DATA;
            r_bus_err <= 1'b1;
            r_state   <= DONE;
          end
`endif
        end
        DONE: begin
`ifdef DMEM_TIMEOUT_EN
          r_bus_err <= 1'b0;
`endif
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // while reset is held the state register is meaningless; only a present op stalls
  always_comb begin
    w_stall = 1'b0;
    if (!rst_n) begin
      w_stall = w_op;
    end else begin
      case (r_state)
        IDLE:      w_stall = w_op;
        REQ, WAIT: w_stall = 1'b1;
        default:   w_stall = 1'b0;
      endcase
    end
  end

  assign mem_stall_MEM = w_stall;
  assign rdata_MEM     = r_rdata;
  assign bus.req_valid = r_req_valid;
  assign bus.req_we    = r_req.we;
  assign bus.req_addr  = r_req.addr;
  assign bus.req_wdata = r_req.wdata;
  assign bus.req_be    = r_req.be;

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

MEM-stage data-memory access controller. It turns each load/store held in the MEM stage into one request on a valid/ready data bus and waits for the matching response. It drives `mem_stall_MEM` into the hazard control unit, which freezes the whole pipeline until the access completes. It is the producer side of the memory-stall path: the hazard unit consumes the stall, and this block generates it.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: response watchdog limit in cycles; used only with `DMEM_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `mem_read_MEM` in 1: load present in MEM.
- `mem_write_MEM` in 1: store present in MEM. Never asserted together with `mem_read_MEM`.
- `addr_MEM` in 32: byte address.
- `wdata_MEM` in 32: store data, already lane-aligned.
- `be_MEM` in 4: byte enables.
- `mem_stall_MEM` out 1: freeze the pipeline. Drives the hazard unit.
- `rdata_MEM` out 32: load data, valid in the DONE cycle.
- `bus_err_MEM` out 1: one-cycle timeout pulse. Exists only with `DMEM_TIMEOUT_EN`.
- `req_valid` out 1: bus request.
- `req_ready` in 1: bus accepts the request.
- `req_we` out 1: 1 = write.
- `req_addr` out 32: word address, `{addr[31:2],2'b00}`.
- `req_wdata` out 32: write data.
- `req_be` out 4: byte enables.
- `resp_valid` in 1: response or write acknowledge; one per accepted request.
- `resp_rdata` in 32: read data.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If `mem_read_MEM|mem_write_MEM`, latch `we`, `req_addr`, `wdata`, `be` into the request registers and go to REQ.
  - `mem_stall_MEM` is asserted combinationally in this same cycle.
- REQ:
  - `req_valid=1` with the latched fields.
  - Stay in REQ until `req_valid&req_ready`, then go to WAIT.
  - Request fields stay stable while waiting.
- WAIT:
  - On `resp_valid`, capture `resp_rdata` into `rdata_MEM` (loads only; stores leave `rdata_MEM` unchanged) and go to DONE.
  - `resp_valid` outside WAIT is ignored.
- DONE:
  - `mem_stall_MEM=0` for exactly one cycle, so the instruction advances.
  - No reissue occurs in this cycle even though the op is still visible in MEM.
  - Next state is IDLE unconditionally.
- `mem_stall_MEM` = (IDLE & op) | REQ | WAIT.
- Back-to-back memory ops: the second op is seen in IDLE the cycle after DONE, and the sequence repeats.
- Non-memory instructions in IDLE: no stall, no bus activity.

## Timing
- Reset values (when `rst_n=0` at an edge): state IDLE, `req_valid=0`, `req_we=0`, `req_addr=0`, `req_wdata=0`, `req_be=0`, `rdata_MEM=0`, `bus_err_MEM=0`, timeout counter 0.
- `mem_stall_MEM` is 0 during reset unless an op is present in MEM.
- Reset mid-transaction drops the request immediately. A late `resp_valid` that arrives afterwards is ignored, because it lands in IDLE.
- Minimum access, with `req_ready=1` at the first REQ cycle and `resp_valid` the cycle after:
  - cycle 0 IDLE (stall)
  - cycle 1 REQ (stall)
  - cycle 2 WAIT (stall)
  - cycle 3 DONE (no stall)
  - This gives 3 stall cycles. Each extra cycle of `req_ready` low or response delay adds one stall cycle.
- `resp_valid` in the same cycle as the request handshake is illegal and is ignored.

## Configuration
- `DMEM_TIMEOUT_EN` defined:
  - A counter clears on entering WAIT and increments each WAIT cycle.
  - When it reaches `TIMEOUT_CYCLES` with no `resp_valid`, go to DONE with `rdata_MEM=32'hDEAD_BEEF` and `bus_err_MEM=1` for that DONE cycle.
  - `resp_valid` in the same cycle as the limit wins: normal completion, no error.
- Undefined: no counter, no `bus_err_MEM` port. WAIT waits indefinitely.

## Structure
- Shared package `dmem_pkg`:
  - state enum `dmem_state_e` (IDLE, REQ, WAIT, DONE)
  - constant `DMEM_ERR_DATA = 32'hDEAD_BEEF`
  - request bundle struct (`we`, `addr`, `wdata`, `be`)
- One sub-module, `dmem_timeout`: a loadable watchdog counter (`clr`, `en`, `expired`), instantiated only under `DMEM_TIMEOUT_EN`.

## Test plan
- Load at `0x0000_1006`, `be=4'b1100`, `req_ready=1` immediately, `resp_valid` next cycle with `0x1234_5678` -> `req_addr=0x0000_1004`, `req_we=0`, stall for exactly 3 cycles, `rdata_MEM=0x1234_5678` in the DONE cycle.
- Store of `0xCAFE_F00D` with `req_ready` low for 4 cycles and ack 2 cycles after acceptance:
  - `req_valid` is held with stable fields for 5 cycles.
  - Stall lasts 8 cycles.
  - `rdata_MEM` is unchanged.
- Back-to-back load then store -> exactly one non-stall DONE cycle between the two accesses, and exactly two bus requests.
- `rst_n` low during WAIT, then `resp_valid` arrives -> state IDLE, `req_valid=0`, response ignored, no DONE cycle.
- With `DMEM_TIMEOUT_EN` and `TIMEOUT_CYCLES=8`, no response -> after 8 WAIT cycles, DONE with `rdata_MEM=0xDEAD_BEEF` and a single-cycle `bus_err_MEM`.
- Non-memory instruction in MEM -> `mem_stall_MEM=0`, `req_valid` stays 0.
